// File: rtl/rpc2_ctrl_cs_timing_gen.sv
// rpc2_ctrl_cs_timing_gen
//
// Memory-clock-domain chip-select sequencer. For each accepted request it
// asserts the selected CS#, then runs the phases
// SETUP -> ACTIVE (data phase) -> HOLD -> RECOVER, and returns to IDLE.
// The timing fields come from the double-flopped memclk synchronizer stage.
// They are snapshotted on acceptance, so register changes made during a
// transaction do not affect it.
//
// Optional feature (macro RPC2_CS_TIMEOUT_EN):
//   Adds a data-phase watchdog. When ACTIVE lasts TIMEOUT_CYCLES cycles
//   without xfer_done, the FSM is forced into HOLD and timeout_err pulses.
//   When the macro is undefined, timeout_err is tied to 0.
//
// Ports:
//   clk, reset_n          memory clock, synchronous active-low reset
//   req_valid/req_ready   request handshake; req_ready is high only in IDLE
//   req_wr, req_sel       timing set select (write/read) and target device
//   reg_{rd,wr}_{css,csh,cshi}{0,1}
//                         4-bit CS setup / hold / high times per device
//   xfer_done             data engine finished (only looked at in ACTIVE)
//   cs0_n, cs1_n          registered chip selects, active low
//   data_phase            high throughout ACTIVE
//   phase_start           one-cycle pulse on the first ACTIVE cycle
//   busy                  high whenever the FSM is not in IDLE
//   timeout_err           one-cycle pulse on watchdog expiry

module rpc2_ctrl_cs_timing_gen #(
    parameter int unsigned TO_W           = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic       req_sel,
    input  logic [3:0] reg_rd_css0,
    input  logic [3:0] reg_rd_css1,
    input  logic [3:0] reg_rd_csh0,
    input  logic [3:0] reg_rd_csh1,
    input  logic [3:0] reg_rd_cshi0,
    input  logic [3:0] reg_rd_cshi1,
    input  logic [3:0] reg_wr_css0,
    input  logic [3:0] reg_wr_css1,
    input  logic [3:0] reg_wr_csh0,
    input  logic [3:0] reg_wr_csh1,
    input  logic [3:0] reg_wr_cshi0,
    input  logic [3:0] reg_wr_cshi1,
    input  logic       xfer_done,
    output logic       cs0_n,
    output logic       cs1_n,
    output logic       data_phase,
    output logic       phase_start,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACTIVE,
        S_HOLD,
        S_RECOVER
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] csh_q;
    logic [3:0] cshi_q;

    logic [3:0] css_m;
    logic [3:0] csh_m;
    logic [3:0] cshi_m;
    logic       to_hit;

    // Timing set selected by the incoming request.
    always_comb begin
        css_m  = '0;
        csh_m  = '0;
        cshi_m = '0;
        case ({req_wr, req_sel})
            2'b00: begin css_m = reg_rd_css0; csh_m = reg_rd_csh0; cshi_m = reg_rd_cshi0; end
            2'b01: begin css_m = reg_rd_css1; csh_m = reg_rd_csh1; cshi_m = reg_rd_cshi1; end
            2'b10: begin css_m = reg_wr_css0; csh_m = reg_wr_csh0; cshi_m = reg_wr_cshi0; end
            default: begin css_m = reg_wr_css1; csh_m = reg_wr_csh1; cshi_m = reg_wr_cshi1; end
        endcase
    end

`ifdef RPC2_CS_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    // Outputs are registered from next-state decisions so that each
    // output changes on the same edge as the state transition it belongs to.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            csh_q       <= '0;
            cshi_q      <= '0;
            cs0_n       <= 1'b1;
            cs1_n       <= 1'b1;
            data_phase  <= 1'b0;
            phase_start <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            req_ready   <= 1'b1;
`ifdef RPC2_CS_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            phase_start <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= S_SETUP;
                        cnt       <= css_m;
                        csh_q     <= csh_m;
                        cshi_q    <= cshi_m;
                        cs0_n     <= req_sel;
                        cs1_n     <= ~req_sel;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (cnt == 4'd0) begin
                        state       <= S_ACTIVE;
                        data_phase  <= 1'b1;
                        phase_start <= 1'b1;
`ifdef RPC2_CS_TIMEOUT_EN
                        to_cnt      <= '0;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ACTIVE: begin
                    // xfer_done takes priority over a simultaneous expiry.
                    if (xfer_done || to_hit) begin
                        state       <= S_HOLD;
                        cnt         <= csh_q;
                        data_phase  <= 1'b0;
                        timeout_err <= to_hit & ~xfer_done;
                    end
`ifdef RPC2_CS_TIMEOUT_EN
                    else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                S_HOLD: begin
                    if (cnt == 4'd0) begin
                        state <= S_RECOVER;
                        cnt   <= cshi_q;
                        cs0_n <= 1'b1;
                        cs1_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RECOVER: begin
                    if (cnt == 4'd0) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cs0_n     <= 1'b1;
                    cs1_n     <= 1'b1;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
